// File: rtl/event_flash_pkg.sv
// -----------------------------------------------------------------------------
// event_flash_pkg
// Shared constants for the HUD event-flash driver:
//   - game-state encodings (ST_*)
//   - 3-bit RGB colour constants (COL_*)
//   - per-channel FSM encoding (ch_state_e)
// Optional build macro used by the design: FLASH_BLINK_EN (blinking flash).
// -----------------------------------------------------------------------------
package event_flash_pkg;

    // Game-state encodings
    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_MENU = 3'b001;
    localparam logic [2:0] ST_PLAY = 3'b010;
    localparam logic [2:0] ST_OVER = 3'b011;

    // RGB colour constants ({R,G,B})
    localparam logic [2:0] COL_OFF  = 3'b000;
    localparam logic [2:0] COL_RED  = 3'b100;
    localparam logic [2:0] COL_CYAN = 3'b011;

    // Channel FSM encoding
    typedef enum logic {
        CH_IDLE  = 1'b0,
        CH_FLASH = 1'b1
    } ch_state_e;

endpackage

// File: rtl/event_flash_ch.sv
// -----------------------------------------------------------------------------
// event_flash_ch
// One flash channel: remembers the last seen value, detects a change while in
// PLAY, and holds its colour on the registered output for HOLD_TICKS ticks.
// A new change during a flash restarts the hold window.
// Build option: FLASH_BLINK_EN -> colour toggles on/off on every tick in FLASH.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   play_i   - 1 while the game is in the PLAY state
//   tick_i   - one-cycle prescaler tick
//   val_i    - watched value
//   color_i  - flash colour for this channel
//   rgb_o    - registered RGB drive
//   active_o - registered, 1 while in FLASH
// -----------------------------------------------------------------------------
module event_flash_ch
    import event_flash_pkg::*;
#(
    parameter int VAL_W      = 4,
    parameter int COL_W      = 3,
    parameter int HOLD_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             play_i,
    input  logic             tick_i,
    input  logic [VAL_W-1:0] val_i,
    input  logic [COL_W-1:0] color_i,
    output logic [COL_W-1:0] rgb_o,
    output logic             active_o
);

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_TICKS);

    ch_state_e        state_q;
    logic [HW-1:0]    hold_q;
    logic [VAL_W-1:0] last_val_q;
    logic [COL_W-1:0] rgb_q;
    logic             active_q;
    logic             chg_s;
`ifdef FLASH_BLINK_EN
    logic             phase_q;  // 1 = colour currently shown
`endif

    // Change detection runs every clock, not only on ticks.
    assign chg_s = (val_i != last_val_q);

    // Channel FSM with registered colour / active outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CH_IDLE;
            hold_q     <= '0;
            last_val_q <= val_i;
            rgb_q      <= '0;
            active_q   <= 1'b0;
`ifdef FLASH_BLINK_EN
            phase_q    <= 1'b1;
`endif
        end else if (!play_i) begin
            // Outside PLAY, keep tracking the value so stale changes never flash.
            state_q    <= CH_IDLE;
            hold_q     <= '0;
            last_val_q <= val_i;
            rgb_q      <= '0;
            active_q   <= 1'b0;
`ifdef FLASH_BLINK_EN
            phase_q    <= 1'b1;
`endif
        end else if (chg_s) begin
            // New event (or retrigger): takes priority over an expiring tick.
            state_q    <= CH_FLASH;
            hold_q     <= HOLD_INIT;
            last_val_q <= val_i;
            rgb_q      <= color_i;
            active_q   <= 1'b1;
`ifdef FLASH_BLINK_EN
            phase_q    <= 1'b1;
`endif
        end else if ((state_q == CH_FLASH) && tick_i) begin
            if (hold_q == HW'(1)) begin
                state_q  <= CH_IDLE;
                hold_q   <= '0;
                rgb_q    <= '0;
                active_q <= 1'b0;
            end else begin
                hold_q   <= hold_q - HW'(1);
`ifdef FLASH_BLINK_EN
                phase_q  <= ~phase_q;
                rgb_q    <= phase_q ? '0 : color_i;
`else
                rgb_q    <= color_i;
`endif
            end
        end else begin
            hold_q <= hold_q;
        end
    end

    assign rgb_o    = rgb_q;
    assign active_o = active_q;

endmodule

// File: rtl/event_flash_rgb.sv
// -----------------------------------------------------------------------------
// event_flash_rgb
// RGB event-flash driver for the game HUD. Watches NUM_CH counters and
// flashes a per-channel colour for HOLD_TICKS prescaler ticks whenever a
// watched value changes while the game is in PLAY_STATE.
// Build option: FLASH_BLINK_EN -> flash blinks on/off every tick.
// Ports:
//   clk          - system clock (everything runs on it)
//   rst          - synchronous active-high reset
//   state        - current game state
//   val_in       - watched values, channel i at [i*VAL_W +: VAL_W]
//   ch_color     - static flash colour per channel
//   rgb_out      - registered RGB drive per channel
//   flash_active - per channel, 1 while flashing
// -----------------------------------------------------------------------------
module event_flash_rgb
    import event_flash_pkg::*;
#(
    parameter int         NUM_CH     = 2,
    parameter int         VAL_W      = 4,
    parameter int         COL_W      = 3,
    parameter int         TICK_DIV   = 25000000,
    parameter int         HOLD_TICKS = 4,
    parameter logic [2:0] PLAY_STATE = ST_PLAY
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              state,
    input  logic [NUM_CH*VAL_W-1:0] val_in,
    input  logic [NUM_CH*COL_W-1:0] ch_color,
    output logic [NUM_CH*COL_W-1:0] rgb_out,
    output logic [NUM_CH-1:0]       flash_active
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0] count_q;
    logic [PS_W-1:0] count_d;
    logic            tick_s;
    logic            play_s;

    assign tick_s = (count_q == PS_LAST);
    assign play_s = (state == PLAY_STATE);

    // Next prescaler count: wrap after the tick cycle.
    always_comb begin
        count_d = count_q + PS_W'(1);
        if (tick_s) begin
            count_d = '0;
        end else begin
            count_d = count_q + PS_W'(1);
        end
    end

    // Free-running prescaler, shared by all channels and independent of state.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        event_flash_ch #(
            .VAL_W      (VAL_W),
            .COL_W      (COL_W),
            .HOLD_TICKS (HOLD_TICKS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .play_i   (play_s),
            .tick_i   (tick_s),
            .val_i    (val_in[i*VAL_W +: VAL_W]),
            .color_i  (ch_color[i*COL_W +: COL_W]),
            .rgb_o    (rgb_out[i*COL_W +: COL_W]),
            .active_o (flash_active[i])
        );
    end

endmodule

// File: tb/tb_event_flash_rgb.sv
// -----------------------------------------------------------------------------
// tb_event_flash_rgb
// Self-checking bench for event_flash_rgb (NUM_CH=2, VAL_W=4, TICK_DIV=4,
// HOLD_TICKS=3). Expected outputs come from an event-time reference model:
// a channel is lit while fewer than HOLD_TICKS prescaler ticks have elapsed
// since its last in-PLAY change.
// -----------------------------------------------------------------------------
module tb_event_flash_rgb;
    import event_flash_pkg::*;

    localparam int NCH  = 2;
    localparam int VW   = 4;
    localparam int CW   = 3;
    localparam int TDIV = 4;
    localparam int HOLD = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [2:0]          state;
    logic [NCH*VW-1:0]   val_in;
    logic [NCH*CW-1:0]   ch_color;
    logic [NCH*CW-1:0]   rgb_out;
    logic [NCH-1:0]      flash_active;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int         edge_idx;      // edges since reset release (tick when (idx+1)%TDIV==0)
    int         evt  [NCH];    // edge index of last in-PLAY change
    bit         valid[NCH];
    logic [3:0] last [NCH];

    event_flash_rgb #(
        .NUM_CH(NCH), .VAL_W(VW), .COL_W(CW),
        .TICK_DIV(TDIV), .HOLD_TICKS(HOLD), .PLAY_STATE(ST_PLAY)
    ) dut (
        .clk(clk), .rst(rst), .state(state), .val_in(val_in),
        .ch_color(ch_color), .rgb_out(rgb_out), .flash_active(flash_active)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Ticks that occurred on edges in (e, k]
    function automatic int ticks_between(input int e, input int k);
        return (k + 1) / TDIV - (e + 1) / TDIV;
    endfunction

    function automatic logic [CW-1:0] col_of(input int c);
        logic [NCH*CW-1:0] cc;
        cc = ch_color;
        return cc[c*CW +: CW];
    endfunction

    function automatic bit model_on(input int c);
        return valid[c] && (ticks_between(evt[c], edge_idx) < HOLD);
    endfunction

    function automatic logic [CW-1:0] model_rgb(input int c);
        if (!model_on(c)) return '0;
`ifdef FLASH_BLINK_EN
        if ((ticks_between(evt[c], edge_idx) % 2) != 0) return '0;
`endif
        return col_of(c);
    endfunction

    // True if channel c would expire on the next edge absent a new change
    function automatic bit expires_next(input int c);
        return valid[c] && (ticks_between(evt[c], edge_idx + 1) == HOLD);
    endfunction

    task automatic set_val(input int c, input logic [3:0] v);
        val_in[c*VW +: VW] = v;
    endtask

    function automatic logic [3:0] get_val(input int c);
        logic [NCH*VW-1:0] vv;
        vv = val_in;
        return vv[c*VW +: VW];
    endfunction

    // One clock: update model with the inputs seen at the edge, then compare.
    task automatic step();
        logic [NCH*CW-1:0] exp_rgb;
        logic [NCH-1:0]    exp_act;
        @(posedge clk);
        if (rst) begin
            edge_idx = -1;
            for (int c = 0; c < NCH; c++) begin
                valid[c] = 1'b0;
                last[c]  = get_val(c);
            end
        end else begin
            edge_idx++;
            for (int c = 0; c < NCH; c++) begin
                if (state != ST_PLAY) begin
                    valid[c] = 1'b0;
                end else if (get_val(c) != last[c]) begin
                    valid[c] = 1'b1;
                    evt[c]   = edge_idx;
                end
                last[c] = get_val(c);
            end
        end
        #1;
        for (int c = 0; c < NCH; c++) begin
            exp_rgb[c*CW +: CW] = model_rgb(c);
            exp_act[c]          = model_on(c);
        end
        chk_val("rgb_out", 32'(rgb_out), 32'(exp_rgb));
        chk_val("flash_active", 32'(flash_active), 32'(exp_act));
    endtask

    initial begin
        int dur;
        bit hit;
        ch_color = {COL_CYAN, COL_RED};
        rst      = 1'b1;
        state    = ST_PLAY;
        val_in   = '0;
        set_val(0, 4'd5);
        set_val(1, 4'd3);
        edge_idx = -1;
        for (int c = 0; c < NCH; c++) begin
            valid[c] = 1'b0;
            evt[c]   = 0;
            last[c]  = 4'd0;
        end
        step();
        step();
        chk_val("reset_rgb", 32'(rgb_out), 32'd0);
        rst = 1'b0;

        // Quiet PLAY: nothing flashes
        for (int i = 0; i < 40; i++) step();

        // ch1 3->4: flash length must fall in 9..12 cycles
        set_val(1, 4'd4);
        dur = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (flash_active[1]) dur++;
        end
        chk_val("ch1_dur_in_range", 32'((dur >= 9) && (dur <= 12)), 32'd1);

        // ch0 double change: one continuous flash
        set_val(0, 4'd6);
        for (int i = 0; i < 6; i++) step();
        set_val(0, 4'd7);
        dur = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (flash_active[0]) dur++;
        end
        chk_val("ch0_ext_dur", 32'((dur >= 9) && (dur <= 12)), 32'd1);

        // Change outside PLAY must not flash on re-entry
        state = ST_IDLE;
        set_val(0, 4'd5);
        step();
        set_val(0, 4'd0);
        for (int i = 0; i < 4; i++) step();
        state = ST_PLAY;
        for (int i = 0; i < 10; i++) step();
        chk_val("no_flash_on_entry", 32'(flash_active), 32'd0);
        set_val(0, 4'd1);
        for (int i = 0; i < 16; i++) step();

        // Wrap-around 15 -> 0 on ch1
        set_val(1, 4'd15);
        for (int i = 0; i < 16; i++) step();
        set_val(1, 4'd0);
        step();
        chk_val("wrap_flash", 32'(flash_active[1]), 32'd1);
        for (int i = 0; i < 15; i++) step();

        // Both channels change together; ch0 changes again on its expiry tick
        set_val(0, 4'd9);
        set_val(1, 4'd10);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (expires_next(0)) begin
                set_val(0, 4'd11);
                step();
                chk_val("retrig_no_gap", 32'(flash_active[0]), 32'd1);
                hit = 1'b1;
            end else begin
                step();
            end
        end
        chk_val("retrig_seen", 32'(hit), 32'd1);
        for (int i = 0; i < 16; i++) step();

        // Reset mid-flash
        set_val(1, 4'd2);
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        chk_val("rst_mid_rgb", 32'(rgb_out), 32'd0);
        chk_val("rst_mid_act", 32'(flash_active), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Randomised phase
        for (int i = 0; i < 600; i++) begin
            state = ($urandom_range(0, 9) == 0) ? ST_MENU : ST_PLAY;
            rst   = ($urandom_range(0, 149) == 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 9) == 0) set_val(c, 4'($urandom_range(0, 15)));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
